// File: rtl/switch_debounce_onehot.sv
// rtl/switch_debounce_onehot.sv - synchronise, debounce and one-hot qualify four raw switch inputs
// Optional build macro: SWITCH_DEBOUNCE_CLEAR_ON_RELEASE_EN (clear onehot when the held switch is released)
module switch_debounce_onehot #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw_raw,
    output logic [3:0] onehot,
    output logic       valid,
    output logic       multi_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD    = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       stable;
    logic [CNT_W-1:0] cnt [4];
    state_t           state;
    logic             stable_single;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 4'b0000;
            sync2 <= 4'b0000;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // Any cycle where the synchronised bit agrees with stable restarts its count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        stable[i] <= sync2[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign stable_single = (stable != 4'b0000) && ((stable & (stable - 4'd1)) == 4'b0000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            onehot    <= 4'b0000;
            valid     <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            multi_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (stable_single) begin
                        onehot <= stable;
                        valid  <= 1'b1;
                        state  <= HELD;
                    end else if (stable != 4'b0000) begin
                        multi_err <= 1'b1;
                        state     <= LOCKOUT;
                    end
                end
                HELD: begin
                    if (stable == onehot) begin
                        state <= HELD;
                    end else if (stable == 4'b0000) begin
`ifdef SWITCH_DEBOUNCE_CLEAR_ON_RELEASE_EN
                        onehot <= 4'b0000;
`endif
                        state <= IDLE;
                    end else if (stable_single && ((stable & onehot) == 4'b0000)) begin
                        // Same-cycle release of the old switch and press of a new one.
                        onehot <= stable;
                        valid  <= 1'b1;
                    end else begin
                        multi_err <= 1'b1;
                        state     <= LOCKOUT;
                    end
                end
                LOCKOUT: begin
                    if (stable == 4'b0000) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_switch_debounce_onehot.sv
// tb/tb_switch_debounce_onehot.sv - directed checks of switch_debounce_onehot with DEBOUNCE_CYCLES=4
module tb_switch_debounce_onehot;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw_raw;
    logic [3:0] onehot;
    logic       valid;
    logic       multi_err;

    int checks = 0;
    int errors = 0;

    switch_debounce_onehot #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw_raw(sw_raw),
        .onehot(onehot),
        .valid(valid),
        .multi_err(multi_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Press for 8 edges: valid exactly at edge 7, onehot switches to code at edge 7.
    task automatic press_expect_valid(input string tag, input logic [3:0] code, input logic [3:0] prev);
        sw_raw = code;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check({tag, "_valid"}, {3'b000, valid}, {3'b000, k == 7});
            check({tag, "_merr"}, {3'b000, multi_err}, 4'b0000);
            check({tag, "_onehot"}, onehot, (k >= 7) ? code : prev);
        end
    endtask

    // Hold a value for n edges with no strobes and onehot at an expected constant.
    task automatic hold_quiet(input string tag, input logic [3:0] val, input int n, input logic [3:0] oh);
        sw_raw = val;
        for (int k = 1; k <= n; k++) begin
            tick();
            check({tag, "_valid"}, {3'b000, valid}, 4'b0000);
            check({tag, "_merr"}, {3'b000, multi_err}, 4'b0000);
            check({tag, "_onehot"}, onehot, oh);
        end
    endtask

    logic [3:0] after_rel;

    initial begin
        rst_n  = 1'b0;
        sw_raw = 4'b1111;
        repeat (3) tick();
        check("rst_onehot", onehot, 4'b0000);
        check("rst_valid", {3'b000, valid}, 4'b0000);
        check("rst_merr", {3'b000, multi_err}, 4'b0000);

        rst_n = 1'b1;
        hold_quiet("post_rst", 4'b0000, 10, 4'b0000);

        // Clean press of switch 1
        press_expect_valid("clean", 4'b0010, 4'b0000);
        hold_quiet("clean_hold", 4'b0010, 4, 4'b0010);

        // Release: sticky by default, cleared at release+7 when the macro is set
        sw_raw = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("rel_valid", {3'b000, valid}, 4'b0000);
`ifdef SWITCH_DEBOUNCE_CLEAR_ON_RELEASE_EN
            check("rel_onehot", onehot, (k >= 7) ? 4'b0000 : 4'b0010);
`else
            check("rel_onehot", onehot, 4'b0010);
`endif
        end
`ifdef SWITCH_DEBOUNCE_CLEAR_ON_RELEASE_EN
        after_rel = 4'b0000;
`else
        after_rel = 4'b0010;
`endif

        // Bounce: toggle every 2 cycles never accumulates DEBOUNCE_CYCLES agreement
        for (int c = 0; c < 20; c++) begin
            sw_raw = (((c / 2) % 2) == 0) ? 4'b0100 : 4'b0000;
            tick();
            check("bounce_valid", {3'b000, valid}, 4'b0000);
            check("bounce_onehot", onehot, after_rel);
        end
        press_expect_valid("bounce_hold", 4'b0100, after_rel);

`ifdef SWITCH_DEBOUNCE_CLEAR_ON_RELEASE_EN
        after_rel = 4'b0000;
`else
        after_rel = 4'b0100;
`endif
        sw_raw = 4'b0000;
        repeat (10) tick();
        check("rel2_onehot", onehot, after_rel);

        // Multi-press: one multi_err at edge 7, onehot unchanged
        sw_raw = 4'b0101;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("multi_merr", {3'b000, multi_err}, {3'b000, k == 7});
            check("multi_valid", {3'b000, valid}, 4'b0000);
            check("multi_onehot", onehot, after_rel);
        end
        hold_quiet("multi_rel", 4'b0000, 10, after_rel);
        press_expect_valid("after_multi", 4'b1000, after_rel);

`ifdef SWITCH_DEBOUNCE_CLEAR_ON_RELEASE_EN
        after_rel = 4'b0000;
`else
        after_rel = 4'b1000;
`endif
        hold_quiet("rel3", 4'b0000, 10, after_rel);

        // Added switch while held
        press_expect_valid("held0", 4'b0001, after_rel);
        sw_raw = 4'b0011;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("added_merr", {3'b000, multi_err}, {3'b000, k == 7});
            check("added_valid", {3'b000, valid}, 4'b0000);
            check("added_onehot", onehot, 4'b0001);
        end
        // Partial release stays in lockout: no valid, no second multi_err
        hold_quiet("partial_rel", 4'b0001, 12, 4'b0001);
        hold_quiet("full_rel", 4'b0000, 10, 4'b0001);
        press_expect_valid("after_lock", 4'b0100, 4'b0001);

`ifdef SWITCH_DEBOUNCE_CLEAR_ON_RELEASE_EN
        after_rel = 4'b0000;
`else
        after_rel = 4'b0100;
`endif
        hold_quiet("rel4", 4'b0000, 10, after_rel);

        // Async reset mid-debounce
        sw_raw = 4'b1000;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_onehot", onehot, 4'b0000);
        check("midrst_valid", {3'b000, valid}, 4'b0000);
        repeat (2) tick();
        check("midrst_hold", onehot, 4'b0000);
        rst_n = 1'b1;
        press_expect_valid("post_midrst", 4'b1000, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_debounce_onehot.md
Name: switch_debounce_onehot

Overview:
- Upstream front end for the 4-to-2 switch encoder.
- Synchronises and debounces four raw mechanical switch inputs, then qualifies presses so that only a clean single-switch press produces a one-hot code.
- The one-hot output drives the encoder's 4-bit input directly. A one-cycle valid strobe marks each new code; an error strobe flags multi-switch presses.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised bit must differ from its stable value before the stable value flips. Legal range 2..2^CNT_W-1.
- CNT_W, 5: width of each per-bit debounce counter.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- sw_raw  input  4  raw asynchronous switch levels, 1 = pressed
- onehot  output  4  registered one-hot code to the encoder; 4'b0000 until the first valid press
- valid  output  1  one-cycle pulse: onehot updated this cycle
- multi_err  output  1  one-cycle pulse: more than one switch is stably pressed

Behaviour:
- Reset (asynchronous, rst_n=0) sets all of the following to 0: sync flops, counters, stable vector, onehot, valid, multi_err. FSM goes to IDLE.
- Synchroniser: two flops per bit; sync2 follows sw_raw after 2 edges.
- Debounce, per bit i:
  - If sync2[i] != stable[i], cnt[i] increments.
  - When cnt[i] == DEBOUNCE_CYCLES-1 and the bit still differs, stable[i] <= sync2[i] and cnt[i] <= 0.
  - If sync2[i] == stable[i], cnt[i] <= 0. Any bounce therefore restarts the count.
  - Counters saturate-free: they never exceed DEBOUNCE_CYCLES-1.
- FSM, evaluated on the stable vector (registered, one cycle after stable changes):
  - IDLE, stable == 0: stay.
  - IDLE, stable has exactly one bit set: onehot <= stable, valid = 1 for one cycle, go to HELD.
  - IDLE, stable has two or more bits set: multi_err = 1 for one cycle, go to LOCKOUT. onehot unchanged.
  - HELD, stable == onehot: stay.
  - HELD, stable == 0: go to IDLE. onehot is retained (sticky) so the encoder output remains stable.
  - HELD, any additional bit set: multi_err pulse, go to LOCKOUT.
  - HELD, a different single bit set with the original released in the same cycle: treat as release then press. onehot <= stable, valid pulse, stay in HELD.
  - LOCKOUT: no valid. Stay until stable == 0, then go to IDLE. A second multi_err is never issued within one lockout.
- Latency: raw edge stable before clock edge 1 gives stable update at edge DEBOUNCE_CYCLES+2, and valid/onehot at edge DEBOUNCE_CYCLES+3.
- valid and multi_err are never high in the same cycle.
- Reset mid-debounce discards all partial counts. After release, the sticky onehot is 0000.

Optional Feature:
- Macro: SWITCH_DEBOUNCE_CLEAR_ON_RELEASE_EN.
- Defined: on the HELD->IDLE transition, onehot <= 4'b0000 in the same cycle. No valid pulse is issued for the clear.
- Undefined: onehot is sticky as described above.
- All other behaviour is identical in both builds.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: hold rst_n=0 with sw_raw=4'b1111 -> onehot=0000, valid=0, multi_err=0. Release rst_n with sw_raw=0 -> outputs stay 0.
- Clean press: sw_raw=0010 set before edge 1 and held 12 cycles -> valid=1 only after edge 7, onehot=0010 from then on. Release -> onehot stays 0010 (macro off) or becomes 0000 at release+7 edges (macro on).
- Bounce: sw_raw toggles 0100/0000 every 2 cycles for 20 cycles, then holds 0100 -> no valid during the toggling; single valid with onehot=0100 seven edges after the hold begins.
- Multi-press: sw_raw=0101 held -> one multi_err pulse at edge 7, onehot unchanged, no valid. Then release, then press 1000 -> valid with onehot=1000.
- Added switch while held: 0001 held, valid seen, then sw_raw=0011 -> single multi_err, LOCKOUT. Releasing to 0001 alone gives no valid; full release required.
- Async reset mid-debounce: press 1000, assert rst_n=0 at edge 4 -> no valid. After deassertion, full 7-edge latency is required again.
